// File: rtl/rf_pulse_deframer_if.sv
// Host-side bundle of the pulse deframer: receiver control, byte read port
// and status flags. The host drives the master side; the deframer is the slave.
interface rf_pulse_deframer_if #(
  parameter int DEPTH = 4
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic            i_rx_en;
  logic            i_rd;
  logic            i_clr_err;
  logic [7:0]      o_rd_data;
  logic            o_pkt_avail;
  logic [CNTW-1:0] o_pkt_cnt;
  logic            o_pkt_rec;
  logic            o_busy;
  logic            o_err;
  logic            o_ovf;

  modport master (
    output i_rx_en, i_rd, i_clr_err,
    input  o_rd_data, o_pkt_avail, o_pkt_cnt, o_pkt_rec, o_busy, o_err, o_ovf
  );

  modport slave (
    input  i_rx_en, i_rd, i_clr_err,
    output o_rd_data, o_pkt_avail, o_pkt_cnt, o_pkt_rec, o_busy, o_err, o_ovf
  );
endinterface

// File: rtl/rf_pulse_deframer.sv
// RF pulse-slot receiver: synchronises the raw pulse train, locks onto an
// evenly spaced preamble, decodes a fixed-length payload with per-pulse
// re-anchoring and queues whole packets for byte-wise reading, MSB first.
//
// cnt holds the number of cycles elapsed since the current anchor: the cycle
// after an anchoring edge reads 1, so an edge that follows the anchor by S
// cycles sees cnt == S and the window is symmetric around SLOT_CYCLES.
// A timeout re-anchors virtually at SLOT_CYCLES, hence the TOL+1 reload.
module rf_pulse_deframer #(
  parameter int SLOT_CYCLES  = 10000,
  parameter int TOL          = 1000,
  parameter int PRE_LEN      = 8,
  parameter int PAYLOAD_BITS = 64,
  parameter int DEPTH        = 4
) (
  input  logic               i_PCLK,
  input  logic               i_PRESETn,
  input  logic               i_rfin,
  rf_pulse_deframer_if.slave bus
);

  localparam int CW     = $clog2(SLOT_CYCLES + TOL + 1);
  localparam int PCW    = $clog2(PRE_LEN + 1);
  localparam int IW     = $clog2(PAYLOAD_BITS);
  localparam int NBYTES = PAYLOAD_BITS / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;

  localparam logic [CW-1:0]  CNT_MAX    = CW'(SLOT_CYCLES + TOL);
  localparam logic [CW-1:0]  CNT_WIN_LO = CW'(SLOT_CYCLES - TOL);
  localparam logic [CW-1:0]  CNT_ANCHOR = CW'(1);
  localparam logic [CW-1:0]  CNT_VIRT   = CW'(TOL + 1);
  localparam logic [PCW-1:0] PC_ONE     = PCW'(1);
  localparam logic [PCW-1:0] PC_LAST    = PCW'(PRE_LEN - 1);
  localparam logic [IW-1:0]  BIT_LAST   = IW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0]  BYTE_LAST  = BW'(NBYTES - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    PUSH    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync2_q, sync3_q, edge_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PCW-1:0]          pc_q, pc_d;
  logic [IW-1:0]           bit_idx_q, bit_idx_d;
  logic [PAYLOAD_BITS-1:0] sr_q, sr_d;
  logic                    err_set, push_req;
  logic                    rise, win, early, tmo, last_bit;

  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]           wptr_q, rptr_q;
  logic [BW-1:0]           bidx_q;
  logic [7:0]              rd_data_q;
  logic                    pkt_rec_q, err_q, ovf_q;
  logic                    fifo_empty, fifo_full, rd_fire, last_byte;
  logic                    pop, push_ok, ovf_set;
  logic [PAYLOAD_BITS-1:0] head;
  logic [7:0]              head_bytes [NBYTES];
  logic [7:0]              head_byte;

  // Two-flop synchroniser followed by a registered rising-edge detector.
  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= i_rfin;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  assign rise     = edge_q & bus.i_rx_en;
  assign win      = (cnt_q >= CNT_WIN_LO);
  assign early    = ~win;
  assign tmo      = (cnt_q == CNT_MAX) & ~rise;
  assign last_bit = (bit_idx_q == BIT_LAST);

  // FSM state register.
  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) state_q <= HUNT;
    else            state_q <= state_d;
  end

  // FSM next-state decision: preamble lock, payload errors and packet push.
  always_comb begin
    state_d = state_q;
    if (!bus.i_rx_en) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT: begin
          if (rise && win && (pc_q == PC_LAST)) state_d = PAYLOAD;
        end
        PAYLOAD: begin
          if (rise && early)              state_d = HUNT;
          else if ((rise || tmo) && last_bit) state_d = PUSH;
        end
        PUSH:    state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Per-state datapath updates: slot counter, preamble count, bit shifting.
  always_comb begin
    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    pc_d      = pc_q;
    bit_idx_d = bit_idx_q;
    sr_d      = sr_q;
    err_set   = 1'b0;
    push_req  = 1'b0;
    if (!bus.i_rx_en) begin
      cnt_d     = '0;
      pc_d      = '0;
      bit_idx_d = '0;
      sr_d      = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (rise) begin
            cnt_d = CNT_ANCHOR;
            if ((pc_q == '0) || early) begin
              pc_d = PC_ONE;
            end else if (pc_q == PC_LAST) begin
              pc_d      = '0;
              bit_idx_d = '0;
              sr_d      = '0;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end else if (pc_q == '0) begin
            cnt_d = '0;
          end else if (tmo) begin
            pc_d  = '0;
            cnt_d = '0;
          end
        end
        PAYLOAD: begin
          if (rise && early) begin
            err_set   = 1'b1;
            sr_d      = '0;
            bit_idx_d = '0;
            pc_d      = '0;
            cnt_d     = '0;
          end else if (rise || tmo) begin
            sr_d      = {sr_q[PAYLOAD_BITS-2:0], rise};
            cnt_d     = rise ? CNT_ANCHOR : CNT_VIRT;
            bit_idx_d = last_bit ? '0 : bit_idx_q + 1'b1;
          end
        end
        PUSH: begin
          push_req  = 1'b1;
          cnt_d     = '0;
          pc_d      = '0;
          bit_idx_d = '0;
        end
        default: begin
          cnt_d = '0;
          pc_d  = '0;
        end
      endcase
    end
  end

  // Decode datapath registers.
  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      cnt_q     <= '0;
      pc_q      <= '0;
      bit_idx_q <= '0;
      sr_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      bit_idx_q <= bit_idx_d;
      sr_q      <= sr_d;
    end
  end

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_fire    = bus.i_rd & ~fifo_empty;
  assign last_byte  = (bidx_q == BYTE_LAST);
  assign pop        = rd_fire & last_byte;
  // A same-cycle final-byte pop frees the slot before the push is judged.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & fifo_full & ~pop;
  assign head       = mem_q[rptr_q[AW-1:0]];

  // Split the head packet into bytes, MSB first.
  always_comb begin
    for (int i = 0; i < NBYTES; i++) begin
      head_bytes[i] = head[PAYLOAD_BITS-1-8*i -: 8];
    end
  end

  assign head_byte = head_bytes[bidx_q];

  // Packet storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge i_PCLK) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= sr_q;
  end

  // FIFO pointers, byte read port and sticky status flags.
  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      bidx_q    <= '0;
      rd_data_q <= '0;
      pkt_rec_q <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (rd_fire) begin
        rd_data_q <= head_byte;
        bidx_q    <= last_byte ? '0 : bidx_q + 1'b1;
      end
      pkt_rec_q <= push_ok;
      err_q     <= err_set | (err_q & ~bus.i_clr_err);
      ovf_q     <= ovf_set | (ovf_q & ~bus.i_clr_err);
    end
  end

  assign bus.o_rd_data   = rd_data_q;
  assign bus.o_pkt_avail = ~fifo_empty;
  assign bus.o_pkt_cnt   = wptr_q - rptr_q;
  assign bus.o_pkt_rec   = pkt_rec_q;
  assign bus.o_busy      = (state_q != HUNT) || (pc_q != '0);
  assign bus.o_err       = err_q;
  assign bus.o_ovf       = ovf_q;

endmodule

// File: tb/tb_rf_pulse_deframer.sv
// Directed bench for rf_pulse_deframer with a byte scoreboard.
module tb_rf_pulse_deframer;
  localparam int SLOT  = 20;
  localparam int TOL   = 4;
  localparam int PRE   = 4;
  localparam int PB    = 16;
  localparam int DEPTH = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rfin = 1'b0;

  int         assertCount = 0;
  int         failCount   = 0;
  logic [7:0] expQ[$];
  int         riseGaps[$];
  int         waited;
  bit         seen;

  rf_pulse_deframer_if #(.DEPTH(DEPTH)) bus ();

  rf_pulse_deframer #(
    .SLOT_CYCLES (SLOT),
    .TOL         (TOL),
    .PRE_LEN     (PRE),
    .PAYLOAD_BITS(PB),
    .DEPTH       (DEPTH)
  ) dut (
    .i_PCLK   (clk),
    .i_PRESETn(rstn),
    .i_rfin   (rfin),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkReadByte(input string tag);
    assertCount++;
    assert (expQ.size() != 0) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected no queued byte", tag, bus.o_rd_data);
    end
    if (expQ.size() != 0) checkOutput(tag, 32'(bus.o_rd_data), 32'(expQ.pop_front()));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_data"},   32'(bus.o_rd_data),   32'd0);
    checkOutput({tag, "_pkt_avail"}, 32'(bus.o_pkt_avail), 32'd0);
    checkOutput({tag, "_pkt_cnt"},   32'(bus.o_pkt_cnt),   32'd0);
    checkOutput({tag, "_pkt_rec"},   32'(bus.o_pkt_rec),   32'd0);
    checkOutput({tag, "_busy"},      32'(bus.o_busy),      32'd0);
    checkOutput({tag, "_err"},       32'(bus.o_err),       32'd0);
    checkOutput({tag, "_ovf"},       32'(bus.o_ovf),       32'd0);
  endtask

  // Nominal schedule: preamble at SLOT spacing, payload zeros are missing pulses.
  task automatic buildFrame(input logic [15:0] payload);
    int pending;
    riseGaps.delete();
    for (int i = 0; i < PRE - 1; i++) riseGaps.push_back(SLOT);
    pending = SLOT;
    for (int b = PB - 1; b >= 0; b--) begin
      if (payload[b]) begin
        riseGaps.push_back(pending);
        pending = SLOT;
      end else begin
        pending += SLOT;
      end
    end
  endtask

  task automatic expectPacket(input logic [15:0] payload);
    expQ.push_back(payload[15:8]);
    expQ.push_back(payload[7:0]);
  endtask

  task automatic pulseOnce();
    rfin = 1'b1;
    tick(2);
    rfin = 1'b0;
  endtask

  // One rise, then one rise after each entry of riseGaps (cycles between rises).
  task automatic applyStimulus();
    pulseOnce();
    foreach (riseGaps[i]) begin
      tick(riseGaps[i] - 2);
      pulseOnce();
    end
  endtask

  task automatic waitPktRec(input int budget, output int cycles, output bit hit);
    cycles = 0;
    hit    = 1'b0;
    while (!hit && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.o_pkt_rec === 1'b1) hit = 1'b1;
    end
  endtask

  task automatic readBytes(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_rd = 1'b1;
      @(negedge clk);
      checkReadByte(tag);
    end
    bus.i_rd = 1'b0;
  endtask

  task automatic clearErrors();
    bus.i_clr_err = 1'b1;
    tick(1);
    bus.i_clr_err = 1'b0;
  endtask

  initial begin
    bus.i_rx_en   = 1'b1;
    bus.i_rd      = 1'b0;
    bus.i_clr_err = 1'b0;
    tick(3);
    checkAllZero("reset");
    rstn = 1'b1;
    tick(2);

    $display("[TB] nominal packet A5C3");
    buildFrame(16'hA5C3);
    expectPacket(16'hA5C3);
    applyStimulus();
    waitPktRec(50, waited, seen);
    checkOutput("nominal_rec_seen", 32'(seen), 32'd1);
    checkOutput("nominal_rec_latency", 32'(waited), 32'd3);
    checkOutput("nominal_pkt_cnt", 32'(bus.o_pkt_cnt), 32'd1);
    checkOutput("nominal_pkt_avail", 32'(bus.o_pkt_avail), 32'd1);
    tick(1);
    checkOutput("nominal_rec_single", 32'(bus.o_pkt_rec), 32'd0);
    readBytes("nominal_read", 2);
    checkOutput("nominal_drained", 32'(bus.o_pkt_avail), 32'd0);
    bus.i_rd = 1'b1;
    tick(1);
    bus.i_rd = 1'b0;
    checkOutput("empty_read_hold", 32'(bus.o_rd_data), 32'hC3);

    $display("[TB] jitter limits accepted");
    riseGaps.delete();
    riseGaps.push_back(16);
    riseGaps.push_back(24);
    riseGaps.push_back(16);
    for (int i = 0; i < 8; i++) begin
      riseGaps.push_back(24);
      riseGaps.push_back(16);
    end
    expectPacket(16'hFFFF);
    applyStimulus();
    waitPktRec(50, waited, seen);
    checkOutput("jitter_rec_seen", 32'(seen), 32'd1);
    readBytes("jitter_read", 2);
    checkOutput("jitter_no_err", 32'(bus.o_err), 32'd0);

    $display("[TB] jitter early pulse rejected");
    riseGaps.delete();
    riseGaps.push_back(16);
    riseGaps.push_back(24);
    riseGaps.push_back(16);
    riseGaps.push_back(24);
    riseGaps.push_back(16);
    riseGaps.push_back(24);
    riseGaps.push_back(16);
    riseGaps.push_back(24);
    riseGaps.push_back(15);
    applyStimulus();
    tick(3);
    checkOutput("early_err", 32'(bus.o_err), 32'd1);
    checkOutput("early_busy", 32'(bus.o_busy), 32'd0);
    waitPktRec(100, waited, seen);
    checkOutput("early_no_packet", 32'(seen), 32'd0);
    checkOutput("early_fifo_empty", 32'(bus.o_pkt_avail), 32'd0);
    clearErrors();
    checkOutput("early_err_cleared", 32'(bus.o_err), 32'd0);

    $display("[TB] trailing zeros 8000");
    buildFrame(16'h8000);
    expectPacket(16'h8000);
    applyStimulus();
    waitPktRec(400, waited, seen);
    checkOutput("trail_rec_seen", 32'(seen), 32'd1);
    checkOutput("trail_rec_latency", 32'(waited), 32'd307);
    readBytes("trail_read", 2);

    $display("[TB] overflow");
    buildFrame(16'h1111);
    expectPacket(16'h1111);
    applyStimulus();
    waitPktRec(200, waited, seen);
    checkOutput("ovf_first_rec", 32'(seen), 32'd1);
    buildFrame(16'h2222);
    expectPacket(16'h2222);
    applyStimulus();
    waitPktRec(200, waited, seen);
    checkOutput("ovf_second_rec", 32'(seen), 32'd1);
    buildFrame(16'h3333);
    applyStimulus();
    waitPktRec(60, waited, seen);
    checkOutput("ovf_third_dropped", 32'(seen), 32'd0);
    checkOutput("ovf_pkt_cnt", 32'(bus.o_pkt_cnt), 32'd2);
    checkOutput("ovf_flag", 32'(bus.o_ovf), 32'd1);
    readBytes("ovf_read", 4);
    clearErrors();
    checkOutput("ovf_cleared", 32'(bus.o_ovf), 32'd0);
    checkOutput("ovf_drained_cnt", 32'(bus.o_pkt_cnt), 32'd0);

    $display("[TB] pop/push collision");
    buildFrame(16'h4444);
    expectPacket(16'h4444);
    applyStimulus();
    waitPktRec(200, waited, seen);
    checkOutput("coll_first_rec", 32'(seen), 32'd1);
    buildFrame(16'h5555);
    expectPacket(16'h5555);
    applyStimulus();
    waitPktRec(200, waited, seen);
    checkOutput("coll_second_rec", 32'(seen), 32'd1);
    checkOutput("coll_full_cnt", 32'(bus.o_pkt_cnt), 32'd2);
    readBytes("coll_first_byte", 1);
    buildFrame(16'h7777);
    expectPacket(16'h7777);
    applyStimulus();
    tick(2);
    bus.i_rd = 1'b1;
    tick(1);
    bus.i_rd = 1'b0;
    checkReadByte("coll_final_byte");
    checkOutput("coll_rec", 32'(bus.o_pkt_rec), 32'd1);
    checkOutput("coll_ovf", 32'(bus.o_ovf), 32'd0);
    checkOutput("coll_cnt", 32'(bus.o_pkt_cnt), 32'd2);
    readBytes("coll_read", 4);
    checkOutput("coll_drained", 32'(bus.o_pkt_avail), 32'd0);

    $display("[TB] receiver enable drop");
    buildFrame(16'h9999);
    expectPacket(16'h9999);
    applyStimulus();
    waitPktRec(60, waited, seen);
    checkOutput("en_packet_rec", 32'(seen), 32'd1);
    riseGaps.delete();
    riseGaps.push_back(SLOT);
    applyStimulus();
    tick(3);
    checkOutput("en_busy_preamble", 32'(bus.o_busy), 32'd1);
    bus.i_rx_en = 1'b0;
    tick(1);
    checkOutput("en_busy_dropped", 32'(bus.o_busy), 32'd0);
    waitPktRec(50, waited, seen);
    checkOutput("en_no_packet", 32'(seen), 32'd0);
    checkOutput("en_fifo_kept", 32'(bus.o_pkt_cnt), 32'd1);
    bus.i_rx_en = 1'b1;
    readBytes("en_read", 1);

    $display("[TB] reset mid-payload");
    riseGaps.delete();
    for (int i = 0; i < 6; i++) riseGaps.push_back(SLOT);
    applyStimulus();
    tick(3);
    checkOutput("rst_busy_before", 32'(bus.o_busy), 32'd1);
    rstn = 1'b0;
    tick(1);
    checkAllZero("mid_reset");
    expQ.delete();
    rstn = 1'b1;
    tick(2);
    bus.i_rd = 1'b1;
    tick(1);
    bus.i_rd = 1'b0;
    checkOutput("post_reset_empty_read", 32'(bus.o_rd_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rf_pulse_deframer.md
# rf_pulse_deframer

Parametrised RF pulse-slot receiver that replaces the fixed preamble/64-bit capture path behind the APB interface. It synchronises the raw `rfin` pulse train and locks onto a run of `PRE_LEN` evenly spaced preamble pulses. It then decodes `PAYLOAD_BITS` bits with per-pulse timing re-anchoring and queues whole packets in a `DEPTH`-entry FIFO, which the APB side drains one byte at a time, MSB first.

## Interface
- `SLOT_CYCLES`, 10000: nominal bit period in `i_PCLK` cycles; 1 ms at 10 MHz.
- `TOL`, 1000: window half-width in cycles; must satisfy 0 < `TOL` < `SLOT_CYCLES`/2.
- `PRE_LEN`, 8: consecutive in-window pulses that declare a preamble; ≥2.
- `PAYLOAD_BITS`, 64: payload length; must be a multiple of 8.
- `DEPTH`, 4: packet FIFO depth; power of two.
- `i_PCLK` in 1: system clock.
- `i_PRESETn` in 1: reset, synchronous, active-low.
- `i_rfin` in 1: asynchronous RF envelope pulse input.
- `i_rx_en` in 1: receiver enable; low forces `HUNT` and clears the decode state, but leaves the FIFO intact.
- `i_rd` in 1: one-cycle pop of one byte from the head packet.
- `i_clr_err` in 1: clears `o_err` and `o_ovf`.
- `o_rd_data` out 8: registered byte from the last `i_rd`.
- `o_pkt_avail` out 1: FIFO non-empty.
- `o_pkt_cnt` out clog2(`DEPTH`)+1: packets stored.
- `o_pkt_rec` out 1: one-cycle pulse when a packet is written.
- `o_busy` out 1: state ≠ `HUNT`, or preamble count > 0.
- `o_err` out 1: sticky framing error.
- `o_ovf` out 1: sticky, set when a packet is dropped on a full FIFO.

## Operation
- **Input conditioning.** `i_rfin` passes through a 2-FF synchroniser plus a rising-edge detector, giving `edge` 3 cycles after the rise. Pulse width is irrelevant; only rising edges count.
- **Slot counter `cnt`.** Width is clog2(`SLOT_CYCLES`+`TOL`+1). It increments every cycle outside `IDLE_HUNT`-idle and saturates.
- **Window test.** `win` = (`SLOT_CYCLES`−`TOL` ≤ `cnt` ≤ `SLOT_CYCLES`+`TOL`). `early` = `cnt` < `SLOT_CYCLES`−`TOL`. `tmo` = (`cnt` == `SLOT_CYCLES`+`TOL`) and no edge.
- **State `HUNT`** (preamble count `pc`):
  - `edge` with `pc`==0 → `pc`=1, `cnt`=0.
  - `edge` and `win` → `pc`+1, `cnt`=0.
  - `edge` and `early` → `pc`=1, `cnt`=0; this is a restart, not an error.
  - `tmo` → `pc`=0.
  - When `pc` reaches `PRE_LEN` → `PAYLOAD`, with `bit_idx`=0 and `cnt`=0, anchored on that edge.
- **State `PAYLOAD`:**
  - `edge` and `win` → shift in 1, `cnt`=0.
  - `tmo` → shift in 0, `cnt`=`TOL`. This is a virtual anchor at `SLOT_CYCLES`.
  - `edge` and `early` → set `o_err`, discard the shift register, go to `HUNT` with `pc`=0. This edge is not reused.
  - Bits shift MSB-first. After bit `PAYLOAD_BITS`−1 is decided → `PUSH`.
- **State `PUSH`** (one cycle):
  - FIFO not full → write the shift register, pulse `o_pkt_rec`.
  - FIFO full → drop the packet, set `o_ovf`.
  - Either way → `HUNT`, `pc`=0.
- **Read side.**
  - Head-byte index `bidx` runs 0..`PAYLOAD_BITS`/8−1.
  - `i_rd` with FIFO non-empty → `o_rd_data` = head[`PAYLOAD_BITS`−1−8·`bidx` -: 8], then `bidx`+1. At the last byte, `bidx` wraps to 0 and the head pops.
  - `i_rd` on an empty FIFO → ignored; `o_rd_data` holds its value.
- **Boundary cases.**
  - A pop of the last byte in the same cycle as a `PUSH` into a full FIFO: the pop is applied first, so the push succeeds and `o_ovf` stays clear.
  - `i_clr_err` in the same cycle as a new error: the set wins.
  - `i_rx_en` low: `HUNT`, `pc`=0, `cnt`=0, no push. The read side keeps working.
  - Read and write pointers are clog2(`DEPTH`)+1 bits and wrap naturally. Full = MSBs differ and the rest are equal.

## Timing
- Reset values: all outputs 0. `HUNT`, `pc`=0, `cnt`=0, FIFO empty, `bidx`=0, synchroniser cleared.
- The 3-cycle detection latency is common to all edges, so intervals are measured exactly.
- Last bit = 1: `PUSH` is the cycle after the edge, and `o_pkt_rec` is high the following cycle. Last bit = 0: the same, counted from `tmo`.
- `o_pkt_avail` and `o_pkt_cnt` update in the same cycle as `o_pkt_rec`.
- `o_rd_data` is valid the cycle after `i_rd`. Back-to-back `i_rd` is supported at one byte per cycle.
- The earliest first packet arrives (`PRE_LEN`+`PAYLOAD_BITS`−1)·`SLOT_CYCLES` + 5 cycles after the first preamble rise, with nominal spacing and the last bit = 1.

## Test plan
Bench parameters: `SLOT_CYCLES`=20, `TOL`=4, `PRE_LEN`=4, `PAYLOAD_BITS`=16, `DEPTH`=2.
- **Nominal packet.** Pulses every 20 cycles: 4 preamble ones, then payload 16'hA5C3, with zeros as missing pulses. → `o_pkt_rec` once; two `i_rd` return 8'hA5, then 8'hC3; `o_pkt_avail` goes to 0.
- **Jitter limits.** Preamble spacings 16, 24, 16, then payload 16'hFFFF at spacings alternating 24/16. → Accepted, data 16'hFFFF. Repeat with one payload spacing of 15. → `o_err`=1, no packet, `o_busy` returns to 0.
- **Trailing zeros.** Payload 16'h8000: a single pulse, then silence. → Packet is written 15 timeouts later, data 8'h80, 8'h00.
- **Overflow.** Three packets 16'h1111, 16'h2222, 16'h3333 with no reads. → `o_pkt_cnt`=2, `o_ovf`=1; reads give 11,11,22,22. Then `i_clr_err` → `o_ovf`=0.
- **Pop/push collision.** FIFO full; issue the final-byte `i_rd` in the `PUSH` cycle. → `o_ovf` stays 0, `o_pkt_cnt` stays 2, and the new packet is readable.
- **Reset and enable.** Assert `i_PRESETn`=0 mid-payload. → All outputs are 0 next cycle. Drop `i_rx_en` mid-preamble. → `o_busy`=0, and the FIFO contents are preserved.
